// File: rtl/sprite_mover.sv
// Sprite origin controller: clamps four-direction moves to the playfield and
// sequences an erase at the old origin followed by a masked redraw at the new one.
module sprite_mover #(
  parameter int                     SPR_W     = 2,
  parameter int                     SPR_H     = 3,
  parameter int                     X_BITS    = 8,
  parameter int                     Y_BITS    = 7,
  parameter int                     STEP      = 1,
  parameter int                     X_MIN     = 0,
  parameter int                     X_MAX     = 158,
  parameter int                     Y_MIN     = 0,
  parameter int                     Y_MAX     = 117,
  parameter int                     X_INIT    = 4,
  parameter int                     Y_INIT    = 58,
  parameter logic [2:0]             FG_COLOUR = 3'b111,
  parameter logic [2:0]             BG_COLOUR = 3'b000,
  parameter logic [SPR_W*SPR_H-1:0] MASK      = 6'b001100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              move_up,
  input  logic              move_down,
  input  logic              move_left,
  input  logic              move_right,
  output logic [X_BITS-1:0] pos_x,
  output logic [Y_BITS-1:0] pos_y,
  output logic [X_BITS-1:0] x_out,
  output logic [Y_BITS-1:0] y_out,
  output logic [2:0]        colour,
  output logic              write_en,
  output logic              busy
);

  localparam int N   = SPR_W * SPR_H;
  localparam int CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int CYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {INIT, IDLE, ERASE, MOVE, DRAW} state_t;

  state_t            state;
  logic [CXW-1:0]    cx, cx_adv;
  logic [CYW-1:0]    cy, cy_adv;
  logic              last_px;
  logic [X_BITS-1:0] tgt_x, tgt_x_next;
  logic [Y_BITS-1:0] tgt_y, tgt_y_next;
  logic              move_req;
  logic [2:0]        draw_colour;
  logic [2:0]        colour_lut [2**IW];
  int                px, py;

  genvar gi;
  generate
    for (gi = 0; gi < 2**IW; gi++) begin : g_lut
      if (gi < N) begin : g_used
        assign colour_lut[gi] = MASK[gi] ? FG_COLOUR : BG_COLOUR;
      end else begin : g_pad
        assign colour_lut[gi] = BG_COLOUR;
      end
    end
  endgenerate

  // Raster advance: cx fastest, cy steps when cx wraps.
  always_comb begin
    cx_adv  = cx + 1'b1;
    cy_adv  = cy;
    if (cx == CXW'(SPR_W - 1)) begin
      cx_adv = '0;
      cy_adv = cy + 1'b1;
    end
    last_px     = (cx == CXW'(SPR_W - 1)) && (cy == CYW'(SPR_H - 1));
    draw_colour = colour_lut[IW'(int'(cy_adv) * SPR_W + int'(cx_adv))];
  end

  // Clamped target; comparisons happen in int so no subtraction can underflow.
  always_comb begin
    px         = int'(pos_x);
    py         = int'(pos_y);
    tgt_x_next = pos_x;
    tgt_y_next = pos_y;
    if (move_up && !move_down)
      tgt_y_next = (py < Y_MIN + STEP) ? Y_BITS'(Y_MIN) : Y_BITS'(py - STEP);
    if (move_down && !move_up)
      tgt_y_next = (py + STEP > Y_MAX) ? Y_BITS'(Y_MAX) : Y_BITS'(py + STEP);
    if (move_left && !move_right)
      tgt_x_next = (px < X_MIN + STEP) ? X_BITS'(X_MIN) : X_BITS'(px - STEP);
    if (move_right && !move_left)
      tgt_x_next = (px + STEP > X_MAX) ? X_BITS'(X_MAX) : X_BITS'(px + STEP);
    move_req = (tgt_x_next != pos_x) || (tgt_y_next != pos_y);
  end

  assign busy = (state != IDLE);

  // Outputs are loaded with the pixel of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      cx       <= '0;
      cy       <= '0;
      pos_x    <= X_BITS'(X_INIT);
      pos_y    <= Y_BITS'(Y_INIT);
      tgt_x    <= X_BITS'(X_INIT);
      tgt_y    <= Y_BITS'(Y_INIT);
      write_en <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      colour   <= '0;
    end else begin
      case (state)
        INIT: begin
          state    <= DRAW;
          cx       <= '0;
          cy       <= '0;
          write_en <= 1'b1;
          x_out    <= pos_x;
          y_out    <= pos_y;
          colour   <= colour_lut[0];
        end
        IDLE: begin
          write_en <= 1'b0;
          if (move_req) begin
            tgt_x    <= tgt_x_next;
            tgt_y    <= tgt_y_next;
            state    <= ERASE;
            cx       <= '0;
            cy       <= '0;
            write_en <= 1'b1;
            x_out    <= pos_x;
            y_out    <= pos_y;
            colour   <= BG_COLOUR;
          end
        end
        ERASE: begin
          if (last_px) begin
            state    <= MOVE;
            write_en <= 1'b0;
          end else begin
            cx       <= cx_adv;
            cy       <= cy_adv;
            write_en <= 1'b1;
            x_out    <= pos_x + X_BITS'(cx_adv);
            y_out    <= pos_y + Y_BITS'(cy_adv);
            colour   <= BG_COLOUR;
          end
        end
        MOVE: begin
          pos_x    <= tgt_x;
          pos_y    <= tgt_y;
          state    <= DRAW;
          cx       <= '0;
          cy       <= '0;
          write_en <= 1'b1;
          x_out    <= tgt_x;
          y_out    <= tgt_y;
          colour   <= colour_lut[0];
        end
        DRAW: begin
          if (last_px) begin
            state    <= IDLE;
            write_en <= 1'b0;
          end else begin
            cx       <= cx_adv;
            cy       <= cy_adv;
            write_en <= 1'b1;
            x_out    <= pos_x + X_BITS'(cx_adv);
            y_out    <= pos_y + Y_BITS'(cy_adv);
            colour   <= draw_colour;
          end
        end
        default: begin
          state    <= INIT;
          write_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: default instance plus a wide-step, full-mask instance.
module tb_sprite_mover;

  localparam logic [5:0] MASK_A = 6'b001100;
  localparam logic [5:0] MASK_B = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, move_up, move_down, move_left, move_right;
  logic [7:0] pos_x, x_out;
  logic [6:0] pos_y, y_out;
  logic [2:0] colour;
  logic       write_en, busy;

  logic       rst_b, b_down;
  logic [7:0] pos_x_b, x_out_b;
  logic [6:0] pos_y_b, y_out_b;
  logic [2:0] colour_b;
  logic       write_en_b, busy_b;

  sprite_mover dut (
    .clk(clk), .reset(reset),
    .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
    .pos_x(pos_x), .pos_y(pos_y), .x_out(x_out), .y_out(y_out),
    .colour(colour), .write_en(write_en), .busy(busy)
  );

  sprite_mover #(
    .SPR_W(3), .SPR_H(2), .STEP(4), .Y_INIT(115), .MASK(MASK_B)
  ) dut_b (
    .clk(clk), .reset(rst_b),
    .move_up(1'b0), .move_down(b_down), .move_left(1'b0), .move_right(1'b0),
    .pos_x(pos_x_b), .pos_y(pos_y_b), .x_out(x_out_b), .y_out(y_out_b),
    .colour(colour_b), .write_en(write_en_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;
  logic [17:0] qa[$];
  logic [17:0] qb[$];
  int mx, my;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected pixel stream for one sprite pass at origin (x,y).
  task automatic push(input int which, input int x, input int y, input bit erase,
                      input int w, input int h, input logic [5:0] mask);
    logic [7:0]  xv;
    logic [6:0]  yv;
    logic [2:0]  c;
    logic [17:0] e;
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        xv = 8'(x + cx);
        yv = 7'(y + cy);
        c  = (!erase && mask[cy * w + cx]) ? 3'd7 : 3'd0;
        e  = {xv, yv, c};
        if (which == 0) qa.push_back(e);
        else qb.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin : mon_a
    logic [17:0] e;
    if (!reset && write_en) begin
      if (qa.size() == 0) check("a_unexpected_write", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_pixel", {x_out, y_out, colour}, e);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [17:0] e;
    if (!rst_b && write_en_b) begin
      if (qb.size() == 0) check("b_unexpected_write", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_pixel", {x_out_b, y_out_b, colour_b}, e);
      end
    end
  end

  // Called just after a negedge while reset is high; releases it and follows the initial draw.
  task automatic release_a(input string tag);
    int cnt;
    mx = 4;
    my = 58;
    reset = 1'b0;
    push(0, mx, my, 0, 2, 3, MASK_A);
    @(negedge clk);
    check({tag, "_first_write"}, write_en, 1);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_draw_cycles"}, cnt, 6);
    check({tag, "_pos_x"}, pos_x, 4);
    check({tag, "_pos_y"}, pos_y, 58);
    check({tag, "_queue_empty"}, qa.size(), 0);
    $display("init %s: drawn at (%0d,%0d) in %0d cycles", tag, pos_x, pos_y, cnt);
  endtask

  // Called just after a negedge with the DUT idle.
  task automatic move_a(input bit u, input bit d, input bit l, input bit r,
                        input int inject_at, input string tag);
    int nx, ny, cnt;
    bit acc;
    nx = mx;
    ny = my;
    if (u && !d) ny = (my < 0 + 1) ? 0 : my - 1;
    if (d && !u) ny = (my + 1 > 117) ? 117 : my + 1;
    if (l && !r) nx = (mx < 0 + 1) ? 0 : mx - 1;
    if (r && !l) nx = (mx + 1 > 158) ? 158 : mx + 1;
    acc = (nx != mx) || (ny != my);
    if (acc) begin
      push(0, mx, my, 1, 2, 3, MASK_A);
      push(0, nx, ny, 0, 2, 3, MASK_A);
    end
    move_up = u; move_down = d; move_left = l; move_right = r;
    @(negedge clk);
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      move_left = (inject_at != 0) && (cnt == inject_at);
      @(negedge clk);
    end
    move_left = 1'b0;
    check({tag, "_busy_cycles"}, cnt, acc ? 13 : 0);
    check({tag, "_pos_x"}, pos_x, nx);
    check({tag, "_pos_y"}, pos_y, ny);
    check({tag, "_queue_empty"}, qa.size(), 0);
    mx = nx;
    my = ny;
    $display("move %s u%0d d%0d l%0d r%0d -> (%0d,%0d) busy %0d", tag, u, d, l, r, pos_x, pos_y, cnt);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; rst_b = 1'b1; b_down = 1'b0;
    move_up = 1'b0; move_down = 1'b0; move_left = 1'b0; move_right = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_write_en", write_en, 0);
    check("rst_busy", busy, 1);
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_colour", colour, 0);
    check("rst_pos_x", pos_x, 4);
    check("rst_pos_y", pos_y, 58);
    check("rst_b_pos_y", pos_y_b, 115);

    rst_b = 1'b0;
    push(1, 4, 115, 0, 3, 2, MASK_B);
    release_a("reset");
    check("b_init_idle", busy_b, 0);
    check("b_init_queue_empty", qb.size(), 0);

    move_a(1, 0, 0, 0, 0, "single_up");
    while (my > 0) move_a(1, 0, 0, 0, 0, "walk_up");

    // Held request against the top limit must never start a sequence.
    move_up = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    move_up = 1'b0;
    check("clamp_hold_busy", cnt, 0);
    move_a(1, 0, 0, 0, 0, "clamp_up");
    move_a(1, 0, 0, 1, 0, "clamp_up_right");
    move_a(1, 1, 0, 0, 0, "cancel_ud");
    move_a(0, 0, 1, 1, 0, "cancel_lr");
    move_a(1, 1, 1, 1, 0, "cancel_all");
    move_a(0, 0, 0, 1, 10, "busy_ignore");
    move_a(0, 0, 0, 0, 0, "no_request");
    move_a(0, 1, 1, 0, 0, "diag_down_left");

    // Reset lands during erase pixel 2 of a move.
    push(0, mx, my, 1, 2, 3, MASK_A);
    move_right = 1'b1;
    @(negedge clk);
    move_right = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_write_en", write_en, 0);
    check("midrst_busy", busy, 1);
    check("midrst_pos_x", pos_x, 4);
    check("midrst_pos_y", pos_y, 58);
    check("midrst_erase_left", qa.size(), 3);
    qa.delete();
    repeat (2) @(negedge clk);
    release_a("midrst");

    // Wide-step instance: move down clamps to the bottom edge.
    push(1, 4, 115, 1, 3, 2, MASK_B);
    push(1, 4, 117, 0, 3, 2, MASK_B);
    b_down = 1'b1;
    @(negedge clk);
    b_down = 1'b0;
    cnt = 0;
    while (busy_b && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("b_down_busy_cycles", cnt, 13);
    check("b_down_pos_y", pos_y_b, 117);
    check("b_down_pos_x", pos_x_b, 4);
    check("b_down_queue_empty", qb.size(), 0);
    $display("move b_down -> (%0d,%0d) busy %0d", pos_x_b, pos_y_b, cnt);

    b_down = 1'b1;
    @(negedge clk);
    b_down = 1'b0;
    cnt = 0;
    while (busy_b && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("b_clamp_busy_cycles", cnt, 0);
    check("b_clamp_pos_y", pos_y_b, 117);
    $display("move b_clamp -> (%0d,%0d) busy %0d", pos_x_b, pos_y_b, cnt);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
